// File: rtl/sdram_bridge_pkg.sv
// Shared types for the SDRAM burst bridge: FSM state encoding and the
// byte-lane order used when packing bytes into 16-bit controller words.
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WREQ,
    WDATA,
    RREQ,
    RDATA,
    RDRAIN
  } state_t;

  // Lane that receives the even (first) byte of each pair: 0 means [7:0].
  localparam logic FIRST_LANE = 1'b0;

  // Maps byte parity within a word to the 16-bit lane it occupies.
  function automatic logic byte_lane(input logic odd);
    return odd ^ FIRST_LANE;
  endfunction

endpackage

// File: rtl/burst_buf.sv
// Single-port BURST_LEN x 16 staging RAM with per-byte-lane write enables.
// Read is asynchronous so the word at the current index is visible at once.
module burst_buf #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic [1:0]       we,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  logic [15:0] mem [DEPTH];

  // Byte-lane writes; contents are never reset.
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sdram_burst_bridge.sv
// Moves byte streams between byte-wide FIFOs and the 16-bit SDRAM
// controller user interface in bursts of BURST_LEN words, with write and
// read pointers that auto-increment inside a wrapping address region.
module sdram_burst_bridge #(
  parameter int ADDR_W       = 24,
  parameter int BURST_LEN    = 8,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 1024
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              wr_trig,
  input  logic              rd_trig,
  input  logic              wfifo_empty,
  output logic              wfifo_rd_en,
  input  logic [7:0]        wfifo_rd_data,
  input  logic              rfifo_full,
  output logic              rfifo_wr_en,
  output logic [7:0]        rfifo_wr_data,
  input  logic              sdrc_init_done,
  input  logic              sdrc_busy_n,
  output logic              sdrc_wr_n,
  output logic              sdrc_rd_n,
  output logic [ADDR_W-1:0] sdrc_addr,
  output logic [8:0]        sdrc_data_len,
  output logic [15:0]       sdrc_data,
  input  logic              sdrc_wrd_ack,
  input  logic              sdrc_rd_valid,
  input  logic [15:0]       sdrc_rdata,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done,
  output logic              trig_ovf
);

  import sdram_bridge_pkg::*;

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W:0]    LAST_BYTE = (IDX_W+1)'(2*BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LIMIT     = ADDR_W'(BASE_ADDR + REGION_WORDS);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);

  // Next burst start address, wrapping back to the region base.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] n;
    n = p + STEP;
    return (n == LIMIT) ? BASE : n;
  endfunction

  state_t            state, state_nxt;
  logic              wr_pend, rd_pend;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W:0]    bcnt;      // byte index for fill and drain
  logic [IDX_W-1:0]  wcnt;      // word index for controller transfers
  logic              pop_pend;  // a FIFO pop issued last cycle, data arrives now
  logic              cap, ack_ev, rv_ev, push, wr_fin, rd_fin;
  logic [IDX_W-1:0]  buf_addr;
  logic [1:0]        buf_we;
  logic [15:0]       buf_wdata, buf_rdata;

  burst_buf #(
    .DEPTH (BURST_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk   (sclk),
    .addr  (buf_addr),
    .we    (buf_we),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  // State register.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic, handshake strobes and per-cycle events.
  always_comb begin
    state_nxt   = state;
    wfifo_rd_en = 1'b0;
    sdrc_wr_n   = 1'b1;
    sdrc_rd_n   = 1'b1;
    cap         = 1'b0;
    ack_ev      = 1'b0;
    rv_ev       = 1'b0;
    push        = 1'b0;
    wr_fin      = 1'b0;
    rd_fin      = 1'b0;
    case (state)
      IDLE: begin
        if (sdrc_init_done) begin
          if (wr_pend)      state_nxt = WFILL;
          else if (rd_pend) state_nxt = RREQ;
        end
      end
      WFILL: begin
        cap         = pop_pend;
        wfifo_rd_en = !pop_pend && !wfifo_empty;
        if (pop_pend && bcnt == LAST_BYTE) state_nxt = WREQ;
      end
      WREQ: begin
        if (sdrc_busy_n) begin
          sdrc_wr_n = 1'b0;
          state_nxt = WDATA;
        end
      end
      WDATA: begin
        ack_ev = sdrc_wrd_ack;
        if (sdrc_wrd_ack && wcnt == LAST_WORD) begin
          wr_fin    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RREQ: begin
        if (sdrc_busy_n) begin
          sdrc_rd_n = 1'b0;
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        rv_ev = sdrc_rd_valid;
        if (sdrc_rd_valid && wcnt == LAST_WORD) state_nxt = RDRAIN;
      end
      RDRAIN: begin
        push = !rfifo_full;
        if (push && bcnt == LAST_BYTE) begin
          rd_fin    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Staging-buffer port: fill writes one lane, read burst writes both lanes.
  always_comb begin
    buf_addr  = wcnt;
    buf_we    = 2'b00;
    buf_wdata = sdrc_rdata;
    case (state)
      WFILL: begin
        buf_addr  = bcnt[IDX_W:1];
        buf_wdata = {wfifo_rd_data, wfifo_rd_data};
        if (cap) buf_we[byte_lane(bcnt[0])] = 1'b1;
      end
      RDATA: begin
        if (rv_ev) buf_we = 2'b11;
      end
      RDRAIN: buf_addr = bcnt[IDX_W:1];
      default: ;
    endcase
  end

  // Trigger bookkeeping: pending flags and the sticky overflow flag.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_pend  <= 1'b0;
      rd_pend  <= 1'b0;
      trig_ovf <= 1'b0;
    end else begin
      if ((wr_trig && wr_pend) || (rd_trig && rd_pend)) trig_ovf <= 1'b1;
      if (wr_trig)     wr_pend <= 1'b1;
      else if (wr_fin) wr_pend <= 1'b0;
      if (rd_trig)     rd_pend <= 1'b1;
      else if (rd_fin) rd_pend <= 1'b0;
    end
  end

  // Byte/word indices, pop tracking, burst pointers and done pulses.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      bcnt     <= '0;
      wcnt     <= '0;
      pop_pend <= 1'b0;
      wr_ptr   <= BASE;
      rd_ptr   <= BASE;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      pop_pend <= wfifo_rd_en;
      wr_done  <= wr_fin;
      rd_done  <= rd_fin;
      if (cap || push) bcnt <= (bcnt == LAST_BYTE) ? '0 : bcnt + 1'b1;
      if (ack_ev || rv_ev) wcnt <= (wcnt == LAST_WORD) ? '0 : wcnt + 1'b1;
      if (wr_fin) wr_ptr <= next_ptr(wr_ptr);
      if (rd_fin) rd_ptr <= next_ptr(rd_ptr);
    end
  end

  assign sdrc_data_len = 9'(BURST_LEN - 1);
  assign busy          = (state != IDLE);
  assign rfifo_wr_en   = push;
  assign sdrc_addr     = (state == WREQ || state == WDATA) ? wr_ptr :
                         (state == RREQ || state == RDATA) ? rd_ptr : '0;
  assign sdrc_data     = (state == WREQ || state == WDATA) ? buf_rdata : '0;
  assign rfifo_wr_data = (state != RDRAIN)     ? 8'h00 :
                         byte_lane(bcnt[0])    ? buf_rdata[15:8] : buf_rdata[7:0];

endmodule

// File: tb/tb_sdram_burst_bridge.sv
// Scoreboard bench for sdram_burst_bridge with a behavioural FIFO and
// SDRAM controller environment and a region-level memory reference model.
module tb_sdram_burst_bridge;

  localparam int ADDR_W = 24;
  localparam int BL     = 8;
  localparam int BASE   = 0;
  localparam int REGION = 16;
  localparam int NB     = 2 * BL;

  logic              sclk = 1'b0;
  logic              s_rst_n = 1'b0;
  logic              wr_trig = 1'b0, rd_trig = 1'b0;
  logic              wfifo_empty = 1'b1;
  logic              wfifo_rd_en;
  logic [7:0]        wfifo_rd_data = 8'h00;
  logic              rfifo_full = 1'b0;
  logic              rfifo_wr_en;
  logic [7:0]        rfifo_wr_data;
  logic              sdrc_init_done = 1'b0;
  logic              sdrc_busy_n = 1'b0;
  logic              sdrc_wr_n, sdrc_rd_n;
  logic [ADDR_W-1:0] sdrc_addr;
  logic [8:0]        sdrc_data_len;
  logic [15:0]       sdrc_data;
  logic              sdrc_wrd_ack = 1'b0, sdrc_rd_valid = 1'b0;
  logic [15:0]       sdrc_rdata = 16'h0000;
  logic              busy, wr_done, rd_done, trig_ovf;

  always #5 sclk = ~sclk;

  sdram_burst_bridge #(
    .ADDR_W(ADDR_W), .BURST_LEN(BL), .BASE_ADDR(BASE), .REGION_WORDS(REGION)
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .wr_trig(wr_trig), .rd_trig(rd_trig),
    .wfifo_empty(wfifo_empty), .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data),
    .rfifo_full(rfifo_full), .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data),
    .sdrc_init_done(sdrc_init_done), .sdrc_busy_n(sdrc_busy_n),
    .sdrc_wr_n(sdrc_wr_n), .sdrc_rd_n(sdrc_rd_n), .sdrc_addr(sdrc_addr),
    .sdrc_data_len(sdrc_data_len), .sdrc_data(sdrc_data),
    .sdrc_wrd_ack(sdrc_wrd_ack), .sdrc_rd_valid(sdrc_rd_valid), .sdrc_rdata(sdrc_rdata),
    .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .trig_ovf(trig_ovf)
  );

  // Reference model and scoreboard queues
  logic [15:0]       ref_mem [REGION];
  logic [15:0]       cmem [256];
  logic [7:0]        q_w[$];
  logic [15:0]       exp_wword[$];
  logic [ADDR_W-1:0] exp_waddr[$], exp_raddr[$], waddr_log[$];
  logic [7:0]        exp_rbyte[$];
  int                req_log[$];
  int m_wptr = BASE, m_rptr = BASE;
  int total = 0, bad = 0;
  int exp_wr_done = 0, exp_rd_done = 0, wr_done_cnt = 0, rd_done_cnt = 0;
  int pop_cnt = 0, wreq_cnt = 0, push_cnt = 0;

  // Environment knobs and controller-model state
  logic force_wempty = 1'b0, force_rfull = 1'b0;
  int   rfull_pct = 0, busy_pct = 20;
  logic real_ack = 1'b0, real_rv = 1'b0, last_rd_en = 1'b0;
  int   c_wr_left = 0, c_rd_left = 0, c_idx = 0;
  logic [ADDR_W-1:0] c_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event with no expectation queued", name);
  endtask

  // Environment: write FIFO source, read FIFO sink, SDRAM controller model
  initial begin
    forever begin
      @(negedge sclk);
      if (!s_rst_n) begin
        c_wr_left = 0; c_rd_left = 0; last_rd_en = 1'b0;
        real_ack = 1'b0; real_rv = 1'b0;
        sdrc_wrd_ack = 1'b0; sdrc_rd_valid = 1'b0;
      end else begin
        if (last_rd_en && q_w.size() > 0) wfifo_rd_data = q_w.pop_front();
        wfifo_empty   = (q_w.size() == 0) || force_wempty;
        rfifo_full    = force_rfull || ($urandom_range(99) < rfull_pct);
        real_ack      = (c_wr_left > 0) && ($urandom_range(3) != 0);
        real_rv       = (c_rd_left > 0) && ($urandom_range(3) != 0);
        sdrc_wrd_ack  = real_ack || (c_wr_left == 0 && $urandom_range(19) == 0);
        sdrc_rd_valid = real_rv  || (c_rd_left == 0 && $urandom_range(19) == 0);
        sdrc_rdata    = real_rv ? cmem[8'(c_addr + c_idx)] : 16'($urandom);
        sdrc_busy_n   = (c_wr_left == 0 && c_rd_left == 0) && ($urandom_range(99) >= busy_pct);
        #1;
        last_rd_en = wfifo_rd_en;
        if (real_ack) begin cmem[8'(c_addr + c_idx)] = sdrc_data; c_idx++; c_wr_left--; end
        if (real_rv)  begin c_idx++; c_rd_left--; end
        if (!sdrc_wr_n) begin c_addr = sdrc_addr; c_idx = 0; c_wr_left = BL; end
        if (!sdrc_rd_n) begin c_addr = sdrc_addr; c_idx = 0; c_rd_left = BL; end
      end
    end
  end

  // Monitor: compares every DUT event against the scoreboard queues
  initial begin
    forever begin
      @(negedge sclk);
      #1;
      if (!s_rst_n) begin
        pop_cnt = 0; wreq_cnt = 0;
      end else begin
        if (wfifo_rd_en) pop_cnt++;
        if (!sdrc_wr_n) begin
          wreq_cnt++;
          req_log.push_back(0);
          waddr_log.push_back(sdrc_addr);
          check("wr_req_after_all_pops", pop_cnt, wreq_cnt * NB);
          if (exp_waddr.size() == 0) fail_now("wr_req");
          else check("wr_addr", sdrc_addr, exp_waddr.pop_front());
        end
        if (!sdrc_rd_n) begin
          req_log.push_back(1);
          if (exp_raddr.size() == 0) fail_now("rd_req");
          else check("rd_addr", sdrc_addr, exp_raddr.pop_front());
        end
        if (!sdrc_wr_n && !sdrc_rd_n) fail_now("both_requests");
        if (real_ack) begin
          if (exp_wword.size() == 0) fail_now("wr_word");
          else check("wr_word", sdrc_data, exp_wword.pop_front());
        end
        if (rfifo_wr_en) begin
          push_cnt++;
          check("push_while_full", rfifo_full, 0);
          if (exp_rbyte.size() == 0) fail_now("rd_byte");
          else check("rd_byte", rfifo_wr_data, exp_rbyte.pop_front());
        end
        if (wr_done) wr_done_cnt++;
        if (rd_done) rd_done_cnt++;
      end
    end
  end

  task automatic prep_write(input logic fixed);
    logic [7:0]  b [NB];
    logic [15:0] w;
    for (int i = 0; i < NB; i++) begin
      b[i] = fixed ? 8'(i) : 8'($urandom);
      q_w.push_back(b[i]);
    end
    for (int i = 0; i < BL; i++) begin
      w = {b[2*i+1], b[2*i]};
      exp_wword.push_back(w);
      ref_mem[m_wptr - BASE + i] = w;
    end
    exp_waddr.push_back(ADDR_W'(m_wptr));
    m_wptr = m_wptr + BL;
    if (m_wptr >= BASE + REGION) m_wptr = BASE;
    exp_wr_done++;
  endtask

  task automatic prep_read();
    for (int i = 0; i < BL; i++) begin
      exp_rbyte.push_back(ref_mem[m_rptr - BASE + i][7:0]);
      exp_rbyte.push_back(ref_mem[m_rptr - BASE + i][15:8]);
    end
    exp_raddr.push_back(ADDR_W'(m_rptr));
    m_rptr = m_rptr + BL;
    if (m_rptr >= BASE + REGION) m_rptr = BASE;
    exp_rd_done++;
  endtask

  task automatic pulse(input logic w, input logic r);
    @(negedge sclk);
    wr_trig = w;
    rd_trig = r;
    @(negedge sclk);
    wr_trig = 1'b0;
    rd_trig = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(wr_done_cnt == exp_wr_done && rd_done_cnt == exp_rd_done && !busy) && n < 4000) begin
      @(negedge sclk);
      n++;
    end
    #2;
    check({name, "_wr_done_count"}, wr_done_cnt, exp_wr_done);
    check({name, "_rd_done_count"}, rd_done_cnt, exp_rd_done);
    check({name, "_wr_words_left"}, exp_wword.size(), 0);
    check({name, "_rd_bytes_left"}, exp_rbyte.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence
  initial begin
    int base, n, busy_seen, wbefore, pbefore, lsz;
    for (int i = 0; i < REGION; i++) ref_mem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) cmem[i] = 16'h0000;

    repeat (3) @(negedge sclk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_wr_n", sdrc_wr_n, 1);
    check("rst_rd_n", sdrc_rd_n, 1);
    check("rst_wfifo_rd_en", wfifo_rd_en, 0);
    check("rst_rfifo_wr_en", rfifo_wr_en, 0);
    check("rst_rfifo_wr_data", rfifo_wr_data, 0);
    check("rst_addr", sdrc_addr, 0);
    check("rst_data", sdrc_data, 0);
    check("rst_done", {wr_done, rd_done}, 0);
    check("rst_ovf", trig_ovf, 0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    check("data_len", sdrc_data_len, BL - 1);

    // Held in IDLE until the controller reports init done
    prep_write(1'b1);
    pulse(1'b1, 1'b0);
    busy_seen = 0;
    repeat (20) begin
      @(negedge sclk);
      #2;
      if (busy) busy_seen++;
    end
    check("gated_busy_cycles", busy_seen, 0);
    check("gated_pops", pop_cnt, 0);
    sdrc_init_done = 1'b1;

    // Write 0x00..0x0F then read it back
    prep_read();
    pulse(1'b0, 1'b1);
    wait_done("wr_then_rd");
    for (int i = 0; i < BL; i++)
      check($sformatf("mem_word%0d", i), cmem[i], 16'((2*i+1)*256 + 2*i));

    // Address wrap over a 16-word region
    lsz = waddr_log.size();
    for (int k = 0; k < 3; k++) begin
      prep_write(1'b0);
      pulse(1'b1, 1'b0);
      wait_done("wrap");
    end
    check("wrap_addr0", waddr_log[lsz], 8);
    check("wrap_addr1", waddr_log[lsz+1], 0);
    check("wrap_addr2", waddr_log[lsz+2], 8);

    // Write FIFO starvation mid-fill
    base = pop_cnt;
    prep_write(1'b0);
    pulse(1'b1, 1'b0);
    n = 0;
    while (pop_cnt < base + 5 && n < 300) begin @(negedge sclk); n++; end
    force_wempty = 1'b1;
    wbefore = wreq_cnt;
    repeat (20) @(negedge sclk);
    #2;
    check("starve_no_request", wreq_cnt, wbefore);
    check("starve_busy", busy, 1);
    force_wempty = 1'b0;
    wait_done("starve");

    // Read FIFO backpressure mid-drain
    base = push_cnt;
    prep_read();
    pulse(1'b0, 1'b1);
    n = 0;
    while (push_cnt < base + 3 && n < 300) begin @(negedge sclk); n++; end
    force_rfull = 1'b1;
    pbefore = push_cnt;
    repeat (10) @(negedge sclk);
    #2;
    check("full_no_push", push_cnt, pbefore);
    force_rfull = 1'b0;
    wait_done("backpressure");

    // Randomised traffic
    rfull_pct = 25;
    busy_pct  = 30;
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(2))
        0: begin prep_write(1'b0); pulse(1'b1, 1'b0); end
        1: begin prep_read(); pulse(1'b0, 1'b1); end
        default: begin
          prep_write(1'b0); pulse(1'b1, 1'b0);
          repeat ($urandom_range(3)) @(negedge sclk);
          prep_read(); pulse(1'b0, 1'b1);
        end
      endcase
      wait_done("random");
    end
    check("ovf_clear_before", trig_ovf, 0);

    // Simultaneous triggers, then a repeated write trigger
    lsz = req_log.size();
    prep_write(1'b0);
    prep_read();
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    wait_done("simul");
    check("ovf_set", trig_ovf, 1);
    check("simul_first_is_write", req_log[lsz], 0);
    check("simul_second_is_read", req_log[lsz+1], 1);

    // Asynchronous reset during the write data phase
    prep_write(1'b0);
    pulse(1'b1, 1'b0);
    n = 0;
    while (!(c_wr_left > 0 && c_idx >= 2) && n < 500) begin @(negedge sclk); n++; end
    check("reached_wdata", c_wr_left > 0, 1);
    #3;
    s_rst_n = 1'b0;
    #1;
    check("abort_wr_n", sdrc_wr_n, 1);
    check("abort_busy", busy, 0);
    check("abort_ovf", trig_ovf, 0);
    q_w.delete();
    exp_wword.delete();
    exp_waddr.delete();
    exp_wr_done--;
    m_wptr = BASE;
    m_rptr = BASE;
    @(negedge sclk);
    @(negedge sclk);
    s_rst_n = 1'b1;
    lsz = waddr_log.size();
    prep_write(1'b0);
    pulse(1'b1, 1'b0);
    prep_read();
    pulse(1'b0, 1'b1);
    wait_done("after_reset");
    check("after_reset_wr_addr", waddr_log[lsz], BASE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_burst_bridge.md
Name: sdram_burst_bridge

Overview:
- Parametrised successor to the fixed UART-to-SDRAM data path.
- Moves byte streams between the byte-wide write/read FIFOs and the 16-bit Gowin SDRAM controller user interface.
- Uses configurable burst length, packs bytes into 16-bit words and auto-increments addresses inside a wrapping region.
- Sits between cmd_decode/FIFOs and SDRAM_controller_top_SIP, replacing the hard-coded single-burst logic.

Parameters:
- ADDR_W, 24, SDRAM controller word-address width.
- BURST_LEN, 8, words per burst (1..256).
- BASE_ADDR, 0, first word address of the test region.
- REGION_WORDS, 1024, region size in words; must be a multiple of BURST_LEN.

Ports:
- sclk  in  1  single clock; same as controller I_sdrc_clk.
- s_rst_n  in  1  asynchronous active-low reset.
- wr_trig  in  1  one-cycle request: write one burst.
- rd_trig  in  1  one-cycle request: read one burst.
- wfifo_empty  in  1  write FIFO empty.
- wfifo_rd_en  out  1  write FIFO pop; data is valid the next cycle.
- wfifo_rd_data  in  8  write FIFO data.
- rfifo_full  in  1  read FIFO full.
- rfifo_wr_en  out  1  read FIFO push.
- rfifo_wr_data  out  8  read FIFO data.
- sdrc_init_done  in  1  controller init complete.
- sdrc_busy_n  in  1  controller ready for a request.
- sdrc_wr_n  out  1  write request, low for one cycle.
- sdrc_rd_n  out  1  read request, low for one cycle.
- sdrc_addr  out  ADDR_W  burst start address.
- sdrc_data_len  out  9  BURST_LEN-1, constant.
- sdrc_data  out  16  write data.
- sdrc_wrd_ack  in  1  high once per accepted write word.
- sdrc_rd_valid  in  1  high once per returned read word.
- sdrc_rdata  in  16  read data.
- busy  out  1  bridge not idle.
- wr_done  out  1  one-cycle pulse at the end of a write burst.
- rd_done  out  1  one-cycle pulse after the last read byte is pushed.
- trig_ovf  out  1  sticky: a trigger arrived while the same kind was already pending.

Behaviour:
- Reset values: all outputs 0 except sdrc_wr_n=1 and sdrc_rd_n=1. Pointers wr_ptr=rd_ptr=BASE_ADDR; pending flags cleared; state IDLE.
- Trigger pending flags:
  - wr_trig and rd_trig each set a pending flag.
  - A trigger while its flag is already set sets trig_ovf; trig_ovf is cleared only by reset.
- IDLE: leave only when sdrc_init_done=1. A pending write goes to WFILL; otherwise a pending read goes to RREQ. If both are pending, the write wins.
- WFILL:
  - Pop 2*BURST_LEN bytes and pack them into the staging buffer. The first byte goes to [7:0], the second to [15:8].
  - Assert wfifo_rd_en only while !wfifo_empty; stall otherwise.
  - At most one pop in flight; data is captured the cycle after each pop.
- WREQ:
  - Present buffer word 0 on sdrc_data and wr_ptr on sdrc_addr.
  - When sdrc_busy_n=1, drive sdrc_wr_n=0 for exactly 1 cycle, then go to WDATA.
  - sdrc_addr stays stable until the burst ends.
- WDATA:
  - Each cycle with sdrc_wrd_ack=1 advances sdrc_data to the next buffer word.
  - After the BURST_LEN-th ack: pulse wr_done, advance wr_ptr by BURST_LEN (wrapping to BASE_ADDR at BASE_ADDR+REGION_WORDS), clear the write-pending flag, return to IDLE.
- RREQ: drive sdrc_addr=rd_ptr. When sdrc_busy_n=1, drive sdrc_rd_n=0 for 1 cycle, then go to RDATA.
- RDATA: each sdrc_rd_valid cycle stores sdrc_rdata at the buffer index and increments the index. After BURST_LEN words go to RDRAIN.
- RDRAIN:
  - Push 2*BURST_LEN bytes to the read FIFO, low byte first, one per cycle while !rfifo_full; stall while full.
  - After the last byte: pulse rd_done, advance rd_ptr with the same wrap rule, clear the read-pending flag, go to IDLE.
- Stray sdrc_wrd_ack or sdrc_rd_valid outside its own state is ignored.
- busy=1 in every state except IDLE.
- Asynchronous reset mid-burst aborts immediately; buffer contents are don't-care afterwards.
- Address arithmetic is ADDR_W bits unsigned; wrap is checked by equality with BASE_ADDR+REGION_WORDS.

Decomposition:
- Package sdram_bridge_pkg holds the state enum (IDLE, WFILL, WREQ, WDATA, RREQ, RDATA, RDRAIN) and the byte-lane order constant.
- Sub-module burst_buf: single-port BURST_LEN×16 staging RAM with byte-lane write enables, shared by the write and read directions.

Test Plan:
- Write then read: BURST_LEN=8; preload 16 bytes 0x00..0x0F; wr_trig then rd_trig; controller model echoes memory -> address 0 written with words 0x0100..0x0F0E; rfifo receives 0x00..0x0F in order; one wr_done and one rd_done pulse.
- Address wrap: REGION_WORDS=16, BURST_LEN=8; three write bursts -> sdrc_addr sequence 0, 8, 0.
- Write FIFO starvation: wfifo_empty high for 20 cycles mid-WFILL -> no sdrc_wr_n request until all 16 bytes are popped; data intact.
- Read FIFO backpressure: rfifo_full held 10 cycles during RDRAIN -> no push while full; no byte lost or duplicated.
- Simultaneous triggers plus overflow: wr_trig and rd_trig in the same cycle, then a second wr_trig while pending -> write burst precedes read; trig_ovf=1.
- Gating and reset: sdrc_init_done=0 holds the bridge in IDLE with busy=0; reset asserted during WDATA -> sdrc_wr_n=1, busy=0, pointers back to BASE_ADDR.
